// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared types and defaults for the data-memory SRAM controller
// Purpose: FSM state encoding, parameter defaults and half-word select constants.
// Ports: none (package).
package arm_mem_pkg;

  localparam int DEF_WAIT_CYCLES = 2;
  localparam int DEF_ADDR_BASE   = 1024;
  localparam int DEF_SRAM_AW     = 18;

  // LSB of the SRAM half-word address selects which half of the 32-bit word.
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/sram_phase_timer.sv
// rtl/sram_phase_timer.sv - wait-state counter for one SRAM half-word phase
// Purpose: counts cycles within a phase; last marks the final cycle of a phase.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset (counter to 0)
//   start in  clear the counter (held while the controller is idle)
//   en    in  count while a phase is active
//   last  out counter has reached WAIT_CYCLES
module sram_phase_timer
  import arm_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  output logic last
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == CW'(WAIT_CYCLES));

  // The counter wraps to 0 on the last cycle so the next phase starts fresh
  // without a separate clear from the controller.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (en) begin
      if (last) cnt_d = '0;
      else      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sram_mem_ctrl.sv
// rtl/sram_mem_ctrl.sv - MEM-stage 32-bit load/store controller for a 16-bit async SRAM
// Purpose: splits each 32-bit access into low/high half-word SRAM phases with
//   programmable wait states; ready low freezes the pipeline while busy.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rd_en, wr_en        load / store request (store wins if both)
//   address             byte address (ALU result)
//   write_data          store data
//   read_data           registered load data, valid from the DONE cycle
//   ready               high when no access is pending
//   sram_addr           SRAM half-word address
//   sram_dq_out/_oe     write data and bus drive enable
//   sram_dq_in          read data from SRAM
//   sram_we_n           active-low write strobe
module sram_mem_ctrl
  import arm_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int ADDR_BASE   = DEF_ADDR_BASE,
  parameter int SRAM_AW     = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  mem_state_e           state_q, state_d;
  logic [SRAM_AW-2:0]   word_q, word_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 wr_q, wr_d;
  logic [31:0]          read_data_q, read_data_d;

  logic                 req;
  logic [31:0]          offset;
  logic                 timer_start, timer_en, timer_last;
  logic                 unused_offset_bits;

  assign req    = rd_en | wr_en;
  assign offset = address - 32'(ADDR_BASE);
  // Only the word index bits that fit the SRAM are kept; the rest wrap away.
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  sram_phase_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (timer_start),
    .en    (timer_en),
    .last  (timer_last)
  );

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    read_data_d = read_data_q;
    timer_start = 1'b0;
    timer_en    = 1'b0;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        timer_start = 1'b1;
        if (req) begin
          word_d  = offset[SRAM_AW:2];
          wdata_d = write_data;
          wr_d    = wr_en;
          state_d = ST_LOW;
        end else begin
          ready = 1'b1;
        end
      end
      ST_LOW: begin
        timer_en  = 1'b1;
        sram_addr = {word_q, HALF_LO};
        if (wr_q) begin
          sram_dq_out = wdata_q[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (timer_last) begin
          if (!wr_q) read_data_d[15:0] = sram_dq_in;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        timer_en  = 1'b1;
        sram_addr = {word_q, HALF_HI};
        if (wr_q) begin
          sram_dq_out = wdata_q[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (timer_last) begin
          if (!wr_q) read_data_d[31:16] = sram_dq_in;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Requests are ignored here so the pipeline sees one ready cycle
        // and advances before the next instruction is sampled in IDLE.
        ready   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;

endmodule
